// File: rtl/clock_time_ctrl_if.sv
// Command/status bundle between the clock controller and its surroundings
// (debounced buttons, 1 Hz tick, the three time counters and the display).
interface clock_time_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       sec_done_inc;
  logic       min_done_inc;
  logic       hour_done_inc;
  logic       sec_inc;
  logic       sec_dec;
  logic       sec_en;
  logic       min_inc;
  logic       min_dec;
  logic       min_en;
  logic       hour_inc;
  logic       hour_dec;
  logic       hour_en;
  logic [1:0] sel_field;
  logic       blink;
  logic       day_pulse;

  // Environment side: drives tick, buttons and counter feedback
  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down,
    output sec_done_inc, min_done_inc, hour_done_inc,
    input  sec_inc, sec_dec, sec_en, min_inc, min_dec, min_en,
    input  hour_inc, hour_dec, hour_en, sel_field, blink, day_pulse
  );

  // Controller side
  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down,
    input  sec_done_inc, min_done_inc, hour_done_inc,
    output sec_inc, sec_dec, sec_en, min_inc, min_dec, min_en,
    output hour_inc, hour_dec, hour_en, sel_field, blink, day_pulse
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the sec/min/hour wrap-around counters:
// carry-cascaded counting in RUN, single-field adjust with no carry in SET_x.
module clock_time_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned TO_W          = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  clock_time_ctrl_if.slave  io_ctl
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_SEC  = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;
  localparam logic [1:0] ST_SET_HOUR = 2'b11;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_nxt;
  logic            r_blink;
  logic            w_blink_nxt;

  logic w_run;
  logic w_set_ok;
  logic w_sec_inc;
  logic w_sec_dec;
  logic w_min_inc;
  logic w_min_dec;
  logic w_hour_inc;
  logic w_hour_dec;

  // State, timeout counter and blink phase registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_RUN;
      r_to_cnt <= '0;
      r_blink  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_nxt;
      r_blink  <= w_blink_nxt;
    end
  end

  // Mode stepping, inactivity timeout and blink phase
  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to_cnt;
    w_blink_nxt = r_blink;
    if (r_state == ST_RUN) begin
      w_to_nxt    = '0;
      w_blink_nxt = 1'b1;
      if (io_ctl.btn_mode) begin
        w_state_nxt = ST_SET_SEC;
      end
    end else begin
      if (io_ctl.btn_mode) begin
        w_state_nxt = (r_state == ST_SET_HOUR) ? ST_RUN : r_state + 2'd1;
        w_to_nxt    = '0;
      end else if (io_ctl.btn_up || io_ctl.btn_down) begin
        w_to_nxt = '0;
      end else if (io_ctl.tick_1hz) begin
        if (r_to_cnt == TO_LAST) begin
          w_state_nxt = ST_RUN;
          w_to_nxt    = '0;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end
      if (w_state_nxt != r_state) begin
        w_blink_nxt = 1'b1;
      end else if (io_ctl.tick_1hz) begin
        w_blink_nxt = ~r_blink;
      end
    end
  end

  // Command decode: kept as separate terms so each counter's done_inc
  // feedback only reaches the next field's command, never its own
  assign w_run    = !i_reset && (r_state == ST_RUN);
  assign w_set_ok = !i_reset && !io_ctl.btn_mode && (io_ctl.btn_up ^ io_ctl.btn_down);

  assign w_sec_inc  = (w_run && io_ctl.tick_1hz)
                    || (w_set_ok && (r_state == ST_SET_SEC) && io_ctl.btn_up);
  assign w_sec_dec  = w_set_ok && (r_state == ST_SET_SEC) && io_ctl.btn_down;
  assign w_min_inc  = (w_run && w_sec_inc && io_ctl.sec_done_inc)
                    || (w_set_ok && (r_state == ST_SET_MIN) && io_ctl.btn_up);
  assign w_min_dec  = w_set_ok && (r_state == ST_SET_MIN) && io_ctl.btn_down;
  assign w_hour_inc = (w_run && w_min_inc && io_ctl.min_done_inc)
                    || (w_set_ok && (r_state == ST_SET_HOUR) && io_ctl.btn_up);
  assign w_hour_dec = w_set_ok && (r_state == ST_SET_HOUR) && io_ctl.btn_down;

  assign io_ctl.sec_inc   = w_sec_inc;
  assign io_ctl.sec_dec   = w_sec_dec;
  assign io_ctl.sec_en    = w_sec_inc || w_sec_dec;
  assign io_ctl.min_inc   = w_min_inc;
  assign io_ctl.min_dec   = w_min_dec;
  assign io_ctl.min_en    = w_min_inc || w_min_dec;
  assign io_ctl.hour_inc  = w_hour_inc;
  assign io_ctl.hour_dec  = w_hour_dec;
  assign io_ctl.hour_en   = w_hour_inc || w_hour_dec;
  assign io_ctl.day_pulse = w_run && w_hour_inc && io_ctl.hour_done_inc;
  assign io_ctl.sel_field = r_state;
  assign io_ctl.blink     = r_blink;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: behavioural counters plus a seconds-of-day
// reference model; directed scenarios followed by random button/tick traffic.
module tb_clock_time_ctrl;

  localparam int unsigned TIMEOUT_TICKS = 10;
  localparam int unsigned TO_W          = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clock_time_ctrl_if u_if ();

  clock_time_ctrl #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TO_W          (TO_W)
  ) u_dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_ctl  (u_if.slave)
  );

  // Behavioural wrap-around counters owned by the bench
  int c_sec  = 0;
  int c_min  = 0;
  int c_hour = 0;
  bit ld     = 1'b0;
  int ld_sec, ld_min, ld_hour;

  assign u_if.sec_done_inc  = u_if.sec_inc  && (c_sec  == 59);
  assign u_if.min_done_inc  = u_if.min_inc  && (c_min  == 59);
  assign u_if.hour_done_inc = u_if.hour_inc && (c_hour == 23);

  always @(posedge clk) begin
    if (ld) begin
      c_sec  <= ld_sec;
      c_min  <= ld_min;
      c_hour <= ld_hour;
    end else begin
      if (u_if.sec_en)  c_sec  <= u_if.sec_inc  ? ((c_sec  == 59) ? 0 : c_sec  + 1)
                                                : ((c_sec  == 0) ? 59 : c_sec  - 1);
      if (u_if.min_en)  c_min  <= u_if.min_inc  ? ((c_min  == 59) ? 0 : c_min  + 1)
                                                : ((c_min  == 0) ? 59 : c_min  - 1);
      if (u_if.hour_en) c_hour <= u_if.hour_inc ? ((c_hour == 23) ? 0 : c_hour + 1)
                                                : ((c_hour == 0) ? 23 : c_hour - 1);
    end
  end

  // Reference model: mode 0..3 (RUN, SET_SEC, SET_MIN, SET_HOUR), time as seconds of day
  int m_mode  = 0;
  int m_to    = 0;
  bit m_blink = 1'b1;
  int m_time  = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hms(input int t);
    return (t / 3600) * 10000 + ((t / 60) % 60) * 100 + (t % 60);
  endfunction

  task automatic load(input int h, input int m, input int s);
    @(negedge clk);
    reset = 1'b0;
    u_if.tick_1hz = 1'b0; u_if.btn_mode = 1'b0; u_if.btn_up = 1'b0; u_if.btn_down = 1'b0;
    ld_hour = h; ld_min = m; ld_sec = s; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    m_time = h * 3600 + m * 60 + s;
  endtask

  // One clock: drive, check commands before the edge, update model, check state after
  task automatic step(input bit rst, input bit tk, input bit md, input bit up, input bit dn);
    logic [9:0] exp_cmd, obs_cmd;
    int h, m, s, old_mode, delta;
    bit si, sd, mi, mdn, hi, hd, day, adj;
    @(negedge clk);
    reset = rst;
    u_if.tick_1hz = tk; u_if.btn_mode = md; u_if.btn_up = up; u_if.btn_down = dn;
    #1;
    h = m_time / 3600; m = (m_time / 60) % 60; s = m_time % 60;
    {si, sd, mi, mdn, hi, hd, day} = '0;
    adj = !rst && (m_mode != 0) && !md && (up != dn);
    if (!rst && m_mode == 0 && tk) begin
      si  = 1'b1;
      mi  = (s == 59);
      hi  = mi && (m == 59);
      day = hi && (h == 23);
    end else if (adj) begin
      case (m_mode)
        1: begin si = up; sd = dn; end
        2: begin mi = up; mdn = dn; end
        default: begin hi = up; hd = dn; end
      endcase
    end
    exp_cmd = {si, sd, si | sd, mi, mdn, mi | mdn, hi, hd, hi | hd, day};
    obs_cmd = {u_if.sec_inc, u_if.sec_dec, u_if.sec_en, u_if.min_inc, u_if.min_dec,
               u_if.min_en, u_if.hour_inc, u_if.hour_dec, u_if.hour_en, u_if.day_pulse};
    check("cmd", 32'(obs_cmd), 32'(exp_cmd));
    @(posedge clk);
    old_mode = m_mode;
    if (rst) begin
      m_mode = 0; m_to = 0; m_blink = 1'b1;
    end else begin
      if (m_mode == 0) begin
        if (tk) m_time = (m_time + 1) % 86400;
        if (md) m_mode = 1;
        m_to = 0;
      end else begin
        if (adj) begin
          delta = up ? 1 : -1;
          case (m_mode)
            1: s = (s + delta + 60) % 60;
            2: m = (m + delta + 60) % 60;
            default: h = (h + delta + 24) % 24;
          endcase
          m_time = h * 3600 + m * 60 + s;
        end
        if (md) begin
          m_mode = (m_mode + 1) % 4; m_to = 0;
        end else if (up || dn) begin
          m_to = 0;
        end else if (tk) begin
          if (m_to == TIMEOUT_TICKS - 1) begin m_mode = 0; m_to = 0; end
          else m_to++;
        end
      end
      if (m_mode != old_mode || m_mode == 0) m_blink = 1'b1;
      else if (tk) m_blink = !m_blink;
    end
    #1;
    check("sel_field", 32'(u_if.sel_field), 32'(m_mode));
    check("blink", 32'(u_if.blink), 32'(m_blink));
    check("time_hhmmss", 32'(c_hour * 10000 + c_min * 100 + c_sec), 32'(hms(m_time)));
  endtask

  initial begin
    reset = 1'b1;
    u_if.tick_1hz = 1'b0; u_if.btn_mode = 1'b0; u_if.btn_up = 1'b0; u_if.btn_down = 1'b0;

    // Reset held with tick and buttons active
    repeat (3) step(1, 1, 1, 1, 0);
    check("reset_sel", 32'(u_if.sel_field), 32'd0);
    check("reset_blink", 32'(u_if.blink), 32'd1);

    // Minute carry on the second tick
    load(12, 34, 58);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("carry_min", 32'(c_hour * 10000 + c_min * 100 + c_sec), 32'd123500);

    // Day wrap
    load(23, 59, 59);
    step(0, 1, 0, 0, 0);
    check("day_wrap", 32'(c_hour * 10000 + c_min * 100 + c_sec), 32'd0);
    step(0, 0, 0, 0, 0);

    // SET_MIN adjust with wrap, no carry; ticks frozen
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    load(10, 59, 30);
    step(0, 0, 0, 1, 0);
    check("set_min_wrap_up", 32'(c_hour * 10000 + c_min * 100 + c_sec), 32'd100030);
    step(0, 0, 0, 0, 1);
    check("set_min_wrap_dn", 32'(c_hour * 10000 + c_min * 100 + c_sec), 32'd105930);
    repeat (3) step(0, 1, 0, 0, 0);

    // SET_HOUR timeout after 10 idle ticks
    step(0, 0, 1, 0, 0);
    repeat (9) step(0, 1, 0, 0, 0);
    check("to_9_still_set", 32'(u_if.sel_field), 32'd3);
    step(0, 1, 0, 0, 0);
    check("to_10_run", 32'(u_if.sel_field), 32'd0);

    // Button press restarts the timeout
    repeat (3) step(0, 0, 1, 0, 0);
    repeat (9) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (9) step(0, 1, 0, 0, 0);
    check("to_restart", 32'(u_if.sel_field), 32'd3);

    // Back to RUN, then SET_SEC conflicts: up&down, mode+up
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    check("at_set_hour", 32'(u_if.sel_field), 32'd3);

    // Reset in SET_HOUR with a button pending
    step(1, 0, 0, 1, 0);
    check("reset_mid_set", 32'(u_if.sel_field), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
